fg_prog_sequencer: RTL and testbench

- Programming sequencer for one island's floating-gate switch fabric.
- Accepts one program or measure command per switch (row, col, pulse count, pulse width).
- Drives the row/column decoder address and enable, the drain-select and prog-switch cutoff enables, and timed Vinj injection pulses, with setup and hold guard intervals.
- Sits between the host command interface and the island's decoder and drain-select tiles.

---
 rtl/fg_prog_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_fg_prog_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fg_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fg_prog_sequencer
// Purpose  : Programming sequencer for one island's floating-gate switch
//            fabric. Takes one program/measure command per switch and drives
//            the decoder address/enable, drain-select, prog-switch cutoff and
//            timed Vinj injection pulses, framed by setup and hold guards.
// Ports    : clk, rst_n (async, active-low)
//            cmd_*      : host command handshake and fields
//            abort      : terminate the command in flight
//            row_addr/col_addr/dec_en : decoder tile controls
//            drain_sel/prog_en        : drain-select tile controls
//            inj_pulse                : Vinj injection pulse
//            meas_req/meas_ack        : external ADC handshake
//            done/status              : completion strobe and result code
// Revision : 1.0 - initial release
// ============================================================================
module fg_prog_sequencer #(
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 6,
  parameter int CNT_BITS  = 8,
  parameter int PW_BITS   = 16,
  parameter int SETUP_CYC = 4,
  parameter int HOLD_CYC  = 4,
  parameter int MEAS_TO   = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ROW_BITS-1:0] cmd_row,
  input  logic [COL_BITS-1:0] cmd_col,
  input  logic [CNT_BITS-1:0] cmd_npulse,
  input  logic [PW_BITS-1:0]  cmd_width,
  input  logic                cmd_meas,
  input  logic                abort,
  output logic [ROW_BITS-1:0] row_addr,
  output logic [COL_BITS-1:0] col_addr,
  output logic                dec_en,
  output logic                drain_sel,
  output logic                prog_en,
  output logic                inj_pulse,
  output logic                meas_req,
  input  logic                meas_ack,
  output logic                done,
  output logic [1:0]          status
);

  localparam int GRD_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int GRD_W   = $clog2(GRD_MAX + 1);
  localparam int MTO_W   = $clog2(MEAS_TO + 1);

  localparam logic [GRD_W-1:0]    SETUP_LD = GRD_W'(SETUP_CYC);
  localparam logic [GRD_W-1:0]    HOLD_LD  = GRD_W'(HOLD_CYC);
  localparam logic [GRD_W-1:0]    GRD_ONE  = GRD_W'(1);
  localparam logic [MTO_W-1:0]    MTO_LD   = MTO_W'(MEAS_TO);
  localparam logic [MTO_W-1:0]    MTO_ONE  = MTO_W'(1);
  localparam logic [PW_BITS-1:0]  PW_ONE   = PW_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ABORT   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_MEAS  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]          state_q,  state_d;
  logic                ready_q,  ready_d;
  logic [ROW_BITS-1:0] row_q,    row_d;
  logic [COL_BITS-1:0] col_q,    col_d;
  logic [CNT_BITS-1:0] rem_q,    rem_d;
  logic [PW_BITS-1:0]  width_q,  width_d;
  logic                meas_q,   meas_d;
  logic [GRD_W-1:0]    grd_q,    grd_d;
  logic [PW_BITS-1:0]  pw_q,     pw_d;
  logic [MTO_W-1:0]    mto_q,    mto_d;
  logic [1:0]          pend_q,   pend_d;
  logic [1:0]          status_q, status_d;

  // A zero width still produces a single-cycle pulse.
  logic [PW_BITS-1:0] width_eff;
  assign width_eff = (width_q == '0) ? PW_ONE : width_q;

  always_comb begin
    state_d  = state_q;
    ready_d  = 1'b1;   // cmd_ready is held off until the first edge after reset
    row_d    = row_q;
    col_d    = col_q;
    rem_d    = rem_q;
    width_d  = width_q;
    meas_d   = meas_q;
    grd_d    = grd_q;
    pw_d     = pw_q;
    mto_d    = mto_q;
    pend_d   = pend_q;
    status_d = status_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          row_d   = cmd_row;
          col_d   = cmd_col;
          rem_d   = cmd_npulse;
          width_d = cmd_width;
          meas_d  = cmd_meas;
          grd_d   = SETUP_LD;
          pend_d  = ST_OK;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (abort) begin
          pend_d  = ST_ABORT;
          grd_d   = HOLD_LD;
          state_d = S_HOLD;
        end else if (grd_q == GRD_ONE) begin
          if (meas_q) begin
            mto_d   = MTO_LD;
            state_d = S_MEAS;
          end else if (rem_q != '0) begin
            pw_d    = width_eff;
            state_d = S_PULSE;
          end else begin
            grd_d   = HOLD_LD;
            state_d = S_HOLD;
          end
        end else begin
          grd_d = grd_q - GRD_ONE;
        end
      end
      S_PULSE: begin
        if (abort) begin
          pend_d  = ST_ABORT;
          grd_d   = HOLD_LD;
          state_d = S_HOLD;
        end else if (pw_q == PW_ONE) begin
          rem_d = rem_q - CNT_ONE;
          // The final pulse goes straight into the hold guard, no gap.
          if (rem_q == CNT_ONE) begin
            grd_d   = HOLD_LD;
            state_d = S_HOLD;
          end else begin
            grd_d   = SETUP_LD;
            state_d = S_GAP;
          end
        end else begin
          pw_d = pw_q - PW_ONE;
        end
      end
      S_GAP: begin
        if (abort) begin
          pend_d  = ST_ABORT;
          grd_d   = HOLD_LD;
          state_d = S_HOLD;
        end else if (grd_q == GRD_ONE) begin
          pw_d    = width_eff;
          state_d = S_PULSE;
        end else begin
          grd_d = grd_q - GRD_ONE;
        end
      end
      S_MEAS: begin
        grd_d = HOLD_LD;
        if (abort) begin
          pend_d  = ST_ABORT;
          state_d = S_HOLD;
        end else if (meas_ack) begin
          pend_d  = ST_OK;
          state_d = S_HOLD;
        end else if (mto_q == MTO_ONE) begin
          pend_d  = ST_TIMEOUT;
          state_d = S_HOLD;
        end else begin
          mto_d = mto_q - MTO_ONE;
        end
      end
      S_HOLD: begin
        if (grd_q == GRD_ONE) begin
          // Publish the result so it is valid alongside the done strobe.
          status_d = pend_q;
          state_d  = S_DONE;
        end else begin
          grd_d = grd_q - GRD_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      rem_q    <= '0;
      width_q  <= '0;
      meas_q   <= 1'b0;
      grd_q    <= '0;
      pw_q     <= '0;
      mto_q    <= '0;
      pend_q   <= ST_OK;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      row_q    <= row_d;
      col_q    <= col_d;
      rem_q    <= rem_d;
      width_q  <= width_d;
      meas_q   <= meas_d;
      grd_q    <= grd_d;
      pw_q     <= pw_d;
      mto_q    <= mto_d;
      pend_q   <= pend_d;
      status_q <= status_d;
    end
  end

  // Enables decode straight from state so an async reset drops them at once.
  logic busy;
  assign busy = (state_q == S_SETUP) || (state_q == S_PULSE) || (state_q == S_GAP) ||
                (state_q == S_MEAS)  || (state_q == S_HOLD);

  assign cmd_ready = (state_q == S_IDLE) && ready_q;
  assign row_addr  = row_q;
  assign col_addr  = col_q;
  assign dec_en    = busy;
  assign drain_sel = busy;
  assign prog_en   = busy;
  // abort gates the pulse and request combinationally, in the same cycle.
  assign inj_pulse = (state_q == S_PULSE) && !abort;
  assign meas_req  = (state_q == S_MEAS) && !abort;
  assign done      = (state_q == S_DONE);
  assign status    = status_q;

endmodule
`default_nettype wire

// File: tb/tb_fg_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fg_prog_sequencer
// Purpose  : Directed self-checking bench for fg_prog_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fg_prog_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_row = '0;
  logic [5:0]  cmd_col = '0;
  logic [7:0]  cmd_npulse = '0;
  logic [15:0] cmd_width = '0;
  logic        cmd_meas = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  row_addr;
  logic [5:0]  col_addr;
  logic        dec_en, drain_sel, prog_en, inj_pulse, meas_req;
  logic        meas_ack = 1'b0;
  logic        done;
  logic [1:0]  status;

  fg_prog_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_npulse(cmd_npulse),
    .cmd_width(cmd_width), .cmd_meas(cmd_meas), .abort(abort),
    .row_addr(row_addr), .col_addr(col_addr), .dec_en(dec_en),
    .drain_sel(drain_sel), .prog_en(prog_en), .inj_pulse(inj_pulse),
    .meas_req(meas_req), .meas_ack(meas_ack), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bits lo..hi set.
  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Trace results: bit k of a vector is the value seen in cycle k after the
  // handshake (cycle 1 is the first cycle with the enables up).
  logic [63:0] en_tr, inj_tr, done_tr, meas_tr, rdy_tr;
  int          meas_cnt, en_cnt, done_cnt, done_cyc, viol;
  logic [1:0]  st_done;

  logic [4:0]  nxt_row;
  logic [5:0]  nxt_col;
  logic [7:0]  nxt_npulse;
  logic [15:0] nxt_width;

  task automatic issue(input logic [4:0] r, input logic [5:0] c, input logic [7:0] np,
                       input logic [15:0] w, input logic m);
    @(negedge clk);
    cmd_row = r; cmd_col = c; cmd_npulse = np; cmd_width = w; cmd_meas = m;
    cmd_valid = 1'b1;
    #1 chk("ready_at_issue", {63'b0, cmd_ready}, 64'd1);
    @(posedge clk);
  endtask

  task automatic run_trace(input int ncyc, input int ack_cyc, input int abort_cyc,
                           input int drop_cyc, input int swap_cyc);
    logic       en, prev_en;
    logic [4:0] prev_row;
    logic [5:0] prev_col;
    en_tr = '0; inj_tr = '0; done_tr = '0; meas_tr = '0; rdy_tr = '0;
    meas_cnt = 0; en_cnt = 0; done_cnt = 0; done_cyc = 0; viol = 0; st_done = 2'b11;
    prev_en = 1'b0; prev_row = '0; prev_col = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      meas_ack = (k == ack_cyc);
      abort    = (k == abort_cyc);
      if (k == drop_cyc) cmd_valid = 1'b0;
      if (k == swap_cyc) begin
        cmd_row = nxt_row; cmd_col = nxt_col; cmd_npulse = nxt_npulse; cmd_width = nxt_width;
      end
      #1;
      en = dec_en & drain_sel & prog_en;
      if ((dec_en != drain_sel) || (dec_en != prog_en)) viol++;
      if (inj_pulse && !en) viol++;
      if (en && prev_en && ((row_addr != prev_row) || (col_addr != prev_col))) viol++;
      prev_en = en; prev_row = row_addr; prev_col = col_addr;
      if (en) en_cnt++;
      if (meas_req) meas_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = k;
        st_done = status;
      end
      if (k < 64) begin
        en_tr[k] = en; inj_tr[k] = inj_pulse; done_tr[k] = done;
        meas_tr[k] = meas_req; rdy_tr[k] = cmd_ready;
      end
    end
    meas_ack = 1'b0;
    abort    = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2;
    chk("rst_ready", {63'b0, cmd_ready}, 64'd0);
    chk("rst_outs", {57'b0, dec_en, drain_sel, prog_en, inj_pulse, meas_req, done, 1'b0}, 64'd0);
    chk("rst_addr_status", {51'b0, row_addr, col_addr, status}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", {63'b0, cmd_ready}, 64'd0);
    @(negedge clk);
    #1 chk("ready_after_release", {63'b0, cmd_ready}, 64'd1);

    // ---------------- two-pulse program ----------------
    issue(5'd3, 6'd17, 8'd2, 16'd5, 1'b0);
    run_trace(26, 0, 0, 1, 0);
    chk("p2_en", en_tr, rng(1, 22));
    chk("p2_inj", inj_tr, rng(5, 9) | rng(14, 18));
    chk("p2_done", done_tr, rng(23, 23));
    chk("p2_status", {62'b0, st_done}, 64'd0);
    chk("p2_addr", {53'b0, row_addr, col_addr}, {53'b0, 5'd3, 6'd17});
    chk("p2_viol", 64'(viol), 64'd0);
    chk("p2_ready_idle", {63'b0, cmd_ready}, 64'd1);

    // ---------------- zero pulses ----------------
    issue(5'd4, 6'd8, 8'd0, 16'd5, 1'b0);
    run_trace(12, 0, 0, 1, 0);
    chk("np0_en", en_tr, rng(1, 8));
    chk("np0_inj", inj_tr, 64'd0);
    chk("np0_done", done_tr, rng(9, 9));
    chk("np0_status", {62'b0, st_done}, 64'd0);

    // ---------------- abort in IDLE is ignored ----------------
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1 chk("idle_abort", {61'b0, cmd_ready, dec_en, done}, 64'b100);

    // ---------------- measure with ack ----------------
    issue(5'd1, 6'd2, 8'd0, 16'd0, 1'b1);
    run_trace(22, 14, 0, 1, 0);
    chk("ms_req", meas_tr, rng(5, 14));
    chk("ms_inj", inj_tr, 64'd0);
    chk("ms_en", en_tr, rng(1, 18));
    chk("ms_done", done_tr, rng(19, 19));
    chk("ms_status", {62'b0, st_done}, 64'd0);

    // ---------------- measure timeout ----------------
    issue(5'd1, 6'd2, 8'd0, 16'd0, 1'b1);
    run_trace(1036, 0, 0, 1, 0);
    chk("to_meas_cnt", 64'(meas_cnt), 64'd1024);
    chk("to_en_cnt", 64'(en_cnt), 64'd1032);
    chk("to_done_cyc", 64'(done_cyc), 64'd1033);
    chk("to_done_cnt", 64'(done_cnt), 64'd1);
    chk("to_status", {62'b0, st_done}, 64'd2);

    // ---------------- abort mid-pulse ----------------
    issue(5'd9, 6'd40, 8'd1, 16'd100, 1'b0);
    run_trace(15, 0, 7, 1, 0);
    chk("ab_inj", inj_tr, rng(5, 6));
    chk("ab_en", en_tr, rng(1, 11));
    chk("ab_done", done_tr, rng(12, 12));
    chk("ab_status", {62'b0, st_done}, 64'd1);
    chk("ab_viol", 64'(viol), 64'd0);

    // ---------------- async reset mid-pulse ----------------
    issue(5'd6, 6'd11, 8'd3, 16'd10, 1'b0);
    run_trace(7, 0, 0, 1, 0);
    chk("rp_in_pulse", {63'b0, inj_pulse}, 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("rp_outs", {57'b0, cmd_ready, dec_en, drain_sel, prog_en, inj_pulse, meas_req, done}, 64'd0);
    chk("rp_status", {62'b0, status}, 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 if (done) done_cnt++;
      @(negedge clk);
    end
    chk("rp_no_done", 64'(done_cnt), 64'd0);
    #1 chk("rp_ready", {62'b0, cmd_ready, dec_en}, 64'b10);

    // ---------------- back-to-back, width 0 ----------------
    nxt_row = 5'd2; nxt_col = 6'd5; nxt_npulse = 8'd1; nxt_width = 16'd2;
    issue(5'd7, 6'd33, 8'd1, 16'd0, 1'b0);
    run_trace(24, 0, 0, 22, 1);
    chk("bb_inj", inj_tr, rng(5, 5) | rng(16, 17));
    chk("bb_en", en_tr, rng(1, 9) | rng(12, 21));
    chk("bb_done", done_tr, rng(10, 10) | rng(22, 22));
    chk("bb_ready", rdy_tr & rng(1, 22), rng(11, 11));
    chk("bb_viol", 64'(viol), 64'd0);
    chk("bb_addr", {53'b0, row_addr, col_addr}, {53'b0, 5'd2, 6'd5});
    chk("bb_status", {62'b0, st_done}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
